// File: rtl/datapath_pkg.sv
// Shared Datapath1 definitions: fetch FSM states, special instruction words and widths.
package datapath_pkg;

    localparam int unsigned PC_WIDTH    = 8;
    localparam int unsigned INSTR_WIDTH = 32;

    localparam logic [31:0] NOP       = 32'h0000_0000;
    localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

endpackage : datapath_pkg

// File: rtl/instr_mem.sv
// Instruction memory: one synchronous write port, one asynchronous read port, no reset.
module instr_mem #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 256
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule : instr_mem

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, loadable instruction memory and IF/ID register,
// with stall, branch redirect/flush and a halt word that stops fetching.
module fetch_stage #(
    parameter int unsigned PC_WIDTH    = datapath_pkg::PC_WIDTH,
    parameter int unsigned INSTR_WIDTH = datapath_pkg::INSTR_WIDTH,
    parameter int unsigned MEM_DEPTH   = 2 ** PC_WIDTH
) (
    input  logic                   clock,
    input  logic                   resetGral,
    input  logic                   loadEnable,
    input  logic [PC_WIDTH-1:0]    loadAddr,
    input  logic [INSTR_WIDTH-1:0] loadData,
    input  logic                   start,
    input  logic                   stall,
    input  logic                   branchTaken,
    input  logic [PC_WIDTH-1:0]    branchTarget,
    output logic [PC_WIDTH-1:0]    fetchOut,
    output logic [INSTR_WIDTH-1:0] instruction,
    output logic [PC_WIDTH-1:0]    pcIFID,
    output logic [PC_WIDTH-1:0]    pcPlusOne,
    output logic                   validIFID,
    output logic                   halted
);

    import datapath_pkg::*;

    localparam logic [INSTR_WIDTH-1:0] L_NOP  = INSTR_WIDTH'(NOP);
    localparam logic [INSTR_WIDTH-1:0] L_HALT = INSTR_WIDTH'(HALT_WORD);

    fetch_state_t            r_state;
    logic [PC_WIDTH-1:0]     r_pc;
    logic [PC_WIDTH-1:0]     r_pc_ifid;
    logic [PC_WIDTH-1:0]     r_pc_plus_one;
    logic [INSTR_WIDTH-1:0]  r_instr;
    logic                    r_valid;
    logic                    r_halted;

    logic                    w_mem_we;
    logic [INSTR_WIDTH-1:0]  w_rd_data;
    logic [PC_WIDTH-1:0]     w_pc_inc;

    // Loads are only accepted while not executing; reset suppresses writes.
    assign w_mem_we = resetGral && loadEnable && (r_state != RUN);
    assign w_pc_inc = r_pc + PC_WIDTH'(1);

    instr_mem #(
        .ADDR_W (PC_WIDTH),
        .DATA_W (INSTR_WIDTH),
        .DEPTH  (MEM_DEPTH)
    ) u_instr_mem (
        .i_clk   (clock),
        .i_we    (w_mem_we),
        .i_waddr (loadAddr),
        .i_wdata (loadData),
        .i_raddr (r_pc),
        .o_rdata (w_rd_data)
    );

    // Fetch FSM, PC and IF/ID register.
    always_ff @(posedge clock) begin
        if (!resetGral) begin
            r_state       <= IDLE;
            r_pc          <= '0;
            r_pc_ifid     <= '0;
            r_pc_plus_one <= PC_WIDTH'(1);
            r_instr       <= L_NOP;
            r_valid       <= 1'b0;
            r_halted      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (!loadEnable && start) begin
                        r_state <= RUN;
                        r_pc    <= '0;
                    end
                end
                RUN: begin
                    if (branchTaken) begin
                        r_pc    <= branchTarget;
                        r_instr <= L_NOP;
                        r_valid <= 1'b0;
                    end else if (stall) begin
                        r_pc <= r_pc;
                    end else if (w_rd_data == L_HALT) begin
                        r_instr  <= L_NOP;
                        r_valid  <= 1'b0;
                        r_halted <= 1'b1;
                        r_state  <= HALT;
                    end else begin
                        r_instr       <= w_rd_data;
                        r_pc_ifid     <= r_pc;
                        r_pc_plus_one <= w_pc_inc;
                        r_valid       <= 1'b1;
                        r_pc          <= w_pc_inc;
                    end
                end
                HALT: begin
                    if (!loadEnable && start) begin
                        r_state  <= RUN;
                        r_pc     <= '0;
                        r_halted <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign fetchOut    = r_pc;
    assign instruction = r_instr;
    assign pcIFID      = r_pc_ifid;
    assign pcPlusOne   = r_pc_plus_one;
    assign validIFID   = r_valid;
    assign halted      = r_halted;

endmodule : fetch_stage

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed program scenarios plus randomized
// control traffic, compared every cycle against a behavioural model.
module tb_fetch_stage;

    logic        clock;
    logic        resetGral;
    logic        loadEnable;
    logic [7:0]  loadAddr;
    logic [31:0] loadData;
    logic        start;
    logic        stall;
    logic        branchTaken;
    logic [7:0]  branchTarget;
    logic [7:0]  fetchOut;
    logic [31:0] instruction;
    logic [7:0]  pcIFID;
    logic [7:0]  pcPlusOne;
    logic        validIFID;
    logic        halted;

    fetch_stage dut (
        .clock        (clock),
        .resetGral    (resetGral),
        .loadEnable   (loadEnable),
        .loadAddr     (loadAddr),
        .loadData     (loadData),
        .start        (start),
        .stall        (stall),
        .branchTaken  (branchTaken),
        .branchTarget (branchTarget),
        .fetchOut     (fetchOut),
        .instruction  (instruction),
        .pcIFID       (pcIFID),
        .pcPlusOne    (pcPlusOne),
        .validIFID    (validIFID),
        .halted       (halted)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: architectural state only.
    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_HALT = 2;

    logic [31:0] m_mem [256];
    int          m_state;
    logic [7:0]  m_pc;
    logic [7:0]  m_pcifid;
    logic [31:0] m_instr;
    logic        m_valid;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_edge();
        if (!resetGral) begin
            m_state  = M_IDLE;
            m_pc     = 8'd0;
            m_pcifid = 8'd0;
            m_instr  = 32'h0;
            m_valid  = 1'b0;
        end else if (m_state == M_RUN) begin
            if (branchTaken) begin
                m_pc    = branchTarget;
                m_instr = 32'h0;
                m_valid = 1'b0;
            end else if (stall) begin
                // everything holds
            end else if (m_mem[m_pc] == 32'hFFFF_FFFF) begin
                m_instr = 32'h0;
                m_valid = 1'b0;
                m_state = M_HALT;
            end else begin
                m_instr  = m_mem[m_pc];
                m_pcifid = m_pc;
                m_valid  = 1'b1;
                m_pc     = m_pc + 8'd1;
            end
        end else begin
            if (loadEnable) m_mem[loadAddr] = loadData;
            else if (start) begin
                m_state = M_RUN;
                m_pc    = 8'd0;
            end
        end
    endtask

    task automatic check_all();
        logic [7:0] pp1;
        pp1 = m_pcifid + 8'd1;
        chk("fetchOut",    32'(fetchOut),    32'(m_pc));
        chk("instruction", instruction,      m_instr);
        chk("pcIFID",      32'(pcIFID),      32'(m_pcifid));
        chk("pcPlusOne",   32'(pcPlusOne),   32'(pp1));
        chk("validIFID",   32'(validIFID),   32'(m_valid));
        chk("halted",      32'(halted),      32'(m_state == M_HALT));
    endtask

    // Drive one cycle of inputs, advance model at the edge, compare #1 later.
    task automatic cyc(input logic rst, input logic le, input logic [7:0] la, input logic [31:0] ld,
                       input logic st, input logic sl, input logic br, input logic [7:0] bt);
        resetGral    = rst;
        loadEnable   = le;
        loadAddr     = la;
        loadData     = ld;
        start        = st;
        stall        = sl;
        branchTaken  = br;
        branchTarget = bt;
        @(posedge clock);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic idle_cyc();
        cyc(1'b1, 1'b0, 8'd0, 32'd0, 1'b0, 1'b0, 1'b0, 8'd0);
    endtask

    task automatic load(input logic [7:0] a, input logic [31:0] d);
        cyc(1'b1, 1'b1, a, d, 1'b0, 1'b0, 1'b0, 8'd0);
    endtask

    task automatic do_start();
        cyc(1'b1, 1'b0, 8'd0, 32'd0, 1'b1, 1'b0, 1'b0, 8'd0);
    endtask

    task automatic do_reset();
        cyc(1'b0, 1'b0, 8'd0, 32'd0, 1'b0, 1'b0, 1'b0, 8'd0);
    endtask

    task automatic do_branch(input logic [7:0] t, input logic sl);
        cyc(1'b1, 1'b0, 8'd0, 32'd0, 1'b0, sl, 1'b1, t);
    endtask

    localparam logic [31:0] W0 = 32'h2040_028A;
    localparam logic [31:0] W1 = 32'h2041_0003;
    localparam logic [31:0] W2 = 32'h0020_1004;
    localparam logic [31:0] WSB = 32'hA0E2_0000;

    initial begin
        logic [31:0] v;
        logic        saw_255;
        logic        wrap_seen;

        resetGral = 1'b0; loadEnable = 1'b0; loadAddr = '0; loadData = '0;
        start = 1'b0; stall = 1'b0; branchTaken = 1'b0; branchTarget = '0;
        for (int i = 0; i < 256; i++) m_mem[i] = 32'h0;
        m_state = M_IDLE; m_pc = 0; m_pcifid = 0; m_instr = 0; m_valid = 0;

        do_reset();
        do_reset();
        chk("rst_pcPlusOne", 32'(pcPlusOne), 32'd1);

        // Fill all words with non-halt values, then run past the wrap.
        for (int i = 0; i < 256; i++) begin
            v = $urandom;
            if (v == 32'hFFFF_FFFF) v = 32'h0;
            load(8'(i), v);
        end
        do_start();
        saw_255 = 1'b0;
        wrap_seen = 1'b0;
        for (int i = 0; i < 260; i++) begin
            idle_cyc();
            if (fetchOut == 8'd255) saw_255 = 1'b1;
            if (saw_255 && fetchOut == 8'd0) wrap_seen = 1'b1;
            if (validIFID && pcIFID == 8'd255) chk("wrap_pcPlusOne", 32'(pcPlusOne), 32'd0);
        end
        chk("wrap_seen", 32'(wrap_seen), 32'd1);

        // Program: three instructions, halt at 3, sb at 7.
        do_reset();
        load(8'd0, W0); load(8'd1, W1); load(8'd2, W2);
        load(8'd3, 32'hFFFF_FFFF); load(8'd7, WSB);
        do_start();
        chk("start_fetchOut", 32'(fetchOut), 32'd0);
        idle_cyc();
        chk("p0_instr", instruction, W0);
        chk("p0_fetchOut", 32'(fetchOut), 32'd1);
        for (int i = 0; i < 2; i++) begin
            cyc(1'b1, 1'b0, 8'd0, 32'd0, 1'b0, 1'b1, 1'b0, 8'd0);
            chk("stall_instr", instruction, W0);
            chk("stall_fetchOut", 32'(fetchOut), 32'd1);
        end
        idle_cyc();
        chk("p1_instr", instruction, W1);
        chk("p1_pcIFID", 32'(pcIFID), 32'd1);
        idle_cyc();
        chk("p2_instr", instruction, W2);
        chk("p2_valid", 32'(validIFID), 32'd1);
        idle_cyc();
        chk("halt_flag", 32'(halted), 32'd1);
        chk("halt_valid", 32'(validIFID), 32'd0);
        // Halt ignores branch and stall.
        do_branch(8'd9, 1'b1);
        chk("halt_ign_br", 32'(fetchOut), 32'd3);

        // Restart from HALT; branch with stall at PC 2.
        do_start();
        idle_cyc();
        idle_cyc();
        chk("pre_br_fetchOut", 32'(fetchOut), 32'd2);
        do_branch(8'd7, 1'b1);
        chk("br_fetchOut", 32'(fetchOut), 32'd7);
        chk("br_bubble", 32'(validIFID), 32'd0);
        chk("br_nop", instruction, 32'h0);
        idle_cyc();
        chk("br_target_instr", instruction, WSB);
        chk("br_target_pc", 32'(pcIFID), 32'd7);

        // Load attempt during RUN must not change memory.
        cyc(1'b1, 1'b1, 8'd0, 32'h1234_5678, 1'b0, 1'b0, 1'b0, 8'd0);
        do_branch(8'd5, 1'b0);
        chk("at_pc5", 32'(fetchOut), 32'd5);
        do_reset();
        chk("midrun_rst_valid", 32'(validIFID), 32'd0);
        do_start();
        idle_cyc();
        chk("restart_word0", instruction, W0);

        // Load and start together in IDLE: write wins, stays IDLE.
        do_reset();
        cyc(1'b1, 1'b1, 8'd10, 32'hCAFE_0010, 1'b1, 1'b0, 1'b0, 8'd0);
        idle_cyc();
        chk("ldstart_idle_pc", 32'(fetchOut), 32'd0);
        chk("ldstart_idle_valid", 32'(validIFID), 32'd0);
        do_start();
        do_branch(8'd10, 1'b0);
        idle_cyc();
        chk("ldstart_word", instruction, 32'hCAFE_0010);

        // Randomized traffic: loads (some halt words), start, stall, branch, reset.
        for (int i = 0; i < 3000; i++) begin
            logic r, le, st, sl, br;
            logic [31:0] d;
            r  = ($urandom_range(0, 39) != 0);
            le = r && ($urandom_range(0, 5) == 0);
            st = ($urandom_range(0, 7) == 0);
            sl = ($urandom_range(0, 4) == 0);
            br = ($urandom_range(0, 7) == 0);
            d  = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
            cyc(r, le, 8'($urandom_range(0, 255)), d, st, sl, br, 8'($urandom_range(0, 255)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_fetch_stage
